mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single fixed-latency memory port.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of loader priority.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  output logic          cpu_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_LDR  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            owner_q;
  logic            m_en_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wdata_q;
  logic            c_done_q;
  logic            l_done_q;
  logic [DW-1:0]   c_rdata_q;
  logic [DW-1:0]   l_rdata_q;
  logic            grant_l_s;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (l_req && c_req) begin
      grant_l_s = (last_q == OWN_CPU);
    end else begin
      grant_l_s = l_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_CPU;
    end else if (state_q == IDLE && (c_req || l_req)) begin
      last_q <= grant_l_s;
    end else begin
      last_q <= last_q;
    end
  end
`else
  assign grant_l_s = l_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_q   <= OWN_CPU;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_done_q  <= 1'b0;
      l_done_q  <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          c_done_q <= 1'b0;
          l_done_q <= 1'b0;
          if (c_req || l_req) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
            owner_q <= grant_l_s;
            m_en_q  <= 1'b1;
            if (grant_l_s) begin
              m_we_q    <= l_we;
              m_addr_q  <= l_addr;
              m_wdata_q <= l_wdata;
            end else begin
              m_we_q    <= c_we;
              m_addr_q  <= c_addr;
              m_wdata_q <= c_wdata;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            m_en_q  <= 1'b0;
            m_we_q  <= 1'b0;
            // m_rdata is only valid on this last BUSY cycle.
            if (owner_q == OWN_LDR) begin
              l_done_q <= 1'b1;
              if (!m_we_q) l_rdata_q <= m_rdata;
            end else begin
              c_done_q <= 1'b1;
              if (!m_we_q) c_rdata_q <= m_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          c_done_q <= 1'b0;
          l_done_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          m_en_q   <= 1'b0;
          m_we_q   <= 1'b0;
          c_done_q <= 1'b0;
          l_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = c_req && !(state_q == RESP && owner_q == OWN_CPU);
  assign c_done    = c_done_q;
  assign l_done    = l_done_q;
  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT=2).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst;
  logic          c_req, c_we, c_done, cpu_stall;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_we, l_done;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_done(l_done), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; m_rdata = '0;
    step(); step();
    checks++; if ({m_en, m_we, c_done, l_done} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {m_en, m_we, c_done, l_done}); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL reset_mbus got %h/%h exp 0/0", m_addr, m_wdata); end
    checks++; if (c_rdata !== 32'h0 || l_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", c_rdata, l_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    c_req = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req got %b exp 1", cpu_stall); end
    step();
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL reset_no_grant got %b exp 0", m_en); end
    c_req = 1'b0; rst = 1'b0;
    step();
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 0", m_en); end
  endtask

  task automatic test_cpu_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; m_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c0 got %b exp 1", cpu_stall); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (m_en !== (k <= 2)) begin errors++; $display("FAIL rd_m_en c%0d got %b exp %b", k, m_en, (k <= 2)); end
      checks++; if (c_done !== (k == 3)) begin errors++; $display("FAIL rd_c_done c%0d got %b exp %b", k, c_done, (k == 3)); end
      checks++; if (cpu_stall !== (k < 3)) begin errors++; $display("FAIL rd_stall c%0d got %b exp %b", k, cpu_stall, (k < 3)); end
      if (k <= 2) begin
        checks++; if (m_addr !== 32'h10 || m_we !== 1'b0) begin errors++; $display("FAIL rd_bus c%0d got %h/%b exp 10/0", k, m_addr, m_we); end
      end
    end
    checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c_rdata got %h exp deadbeef", c_rdata); end
    checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL rd_l_done got %b exp 0", l_done); end
    c_req = 1'b0;
    step();
    checks++; if (c_done !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL rd_after got %b/%b exp 0/0", c_done, m_en); end
  endtask

  task automatic test_cpu_write();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h1234; m_rdata = 32'hCAFEF00D;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (m_we !== (k <= 2) || m_en !== (k <= 2)) begin errors++; $display("FAIL wr_en c%0d got %b/%b exp %b", k, m_en, m_we, (k <= 2)); end
      checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL wr_l_done c%0d got %b exp 0", k, l_done); end
      if (k <= 2) begin
        checks++; if (m_addr !== 32'h20 || m_wdata !== 32'h1234) begin errors++; $display("FAIL wr_bus c%0d got %h/%h exp 20/1234", k, m_addr, m_wdata); end
      end
    end
    checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL wr_c_done got %b exp 1", c_done); end
    checks++; if (c_rdata !== 32'hDEADBEEF || l_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_kept got %h/%h exp deadbeef/0", c_rdata, l_rdata); end
    c_req = 1'b0; c_we = 1'b0;
    step();
  endtask

  task automatic test_tie();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h30; m_rdata = 32'h11112222;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (l_done !== (k == 3) || c_done !== (k == 7)) begin errors++; $display("FAIL tie_done c%0d got l%b c%b", k, l_done, c_done); end
      if (k == 1) begin
        checks++; if (m_addr !== 32'h30) begin errors++; $display("FAIL tie_first got %h exp 30", m_addr); end
      end
      if (k == 3) begin
        checks++; if (l_rdata !== 32'h11112222) begin errors++; $display("FAIL tie_l_rdata got %h exp 11112222", l_rdata); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL tie_stall got %b exp 1", cpu_stall); end
        l_req = 1'b0; m_rdata = 32'h33334444;
      end
      if (k == 5) begin
        checks++; if (m_addr !== 32'h40 || m_en !== 1'b1) begin errors++; $display("FAIL tie_second got %h/%b exp 40/1", m_addr, m_en); end
      end
    end
    checks++; if (c_rdata !== 32'h33334444) begin errors++; $display("FAIL tie_c_rdata got %h exp 33334444", c_rdata); end
    c_req = 1'b0;
    step();
  endtask

  task automatic test_drop_mid();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h50; m_rdata = 32'h55AA55AA;
    step();
    checks++; if (m_addr !== 32'h50) begin errors++; $display("FAIL drop_addr0 got %h exp 50", m_addr); end
    c_req = 1'b0; c_addr = 32'h99; c_we = 1'b1;
    step();
    checks++; if (m_addr !== 32'h50 || m_we !== 1'b0 || m_en !== 1'b1) begin errors++; $display("FAIL drop_hold got %h/%b/%b exp 50/0/1", m_addr, m_we, m_en); end
    step();
    checks++; if (c_done !== 1'b1 || c_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL drop_done got %b/%h exp 1/55aa55aa", c_done, c_rdata); end
    step();
    checks++; if (m_en !== 1'b0 || c_done !== 1'b0) begin errors++; $display("FAIL drop_idle got %b/%b exp 0/0", m_en, c_done); end
    c_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80; m_rdata = 32'h0BADF00D;
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++; if (c_done !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_done c%0d got %b exp %b", k, c_done, (k % 4 == 3)); end
      checks++; if (m_en !== (k % 4 == 1 || k % 4 == 2)) begin errors++; $display("FAIL b2b_m_en c%0d got %b", k, m_en); end
    end
    c_req = 1'b0;
    step();
  endtask

  task automatic test_arb_sustained();
    logic [AW-1:0] exp_addr;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h70;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h60;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k % 4 == 1) begin
`ifdef MEM_ARB_RR_EN
        exp_addr = (((k / 4) % 2) == 0) ? 32'h60 : 32'h70;
`else
        exp_addr = 32'h60;
`endif
        checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL arb_order grant%0d got %h exp %h", k / 4, m_addr, exp_addr); end
      end
    end
    c_req = 1'b0; l_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'hA0; c_wdata = 32'h77;
    step();
    checks++; if (m_en !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b/%b exp 1/1", m_en, m_we); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (m_en !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b/%b exp 0/0", m_en, m_we); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", m_addr); end
    step();
    checks++; if (c_done !== 1'b0 || l_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %b/%b exp 0/0", c_done, l_done); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", c_rdata); end
    rst = 1'b0;
    #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rstmid_release got %b exp 0", m_en); end
    step();
    checks++; if (m_en !== 1'b1 || m_addr !== 32'hA0) begin errors++; $display("FAIL rstmid_regrant got %b/%h exp 1/a0", m_en, m_addr); end
    step(); step();
    checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", c_done); end
    c_req = 1'b0; c_we = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_tie();
    test_drop_mid();
    test_back_to_back();
    test_arb_sustained();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
